// File: rtl/mc_control.sv
// Multicycle MIPS control FSM: Moore-decoded datapath selects/enables from the
// state register, with the branch PC enable taken combinationally from zero.
module mc_control (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] func,
  input  logic       zero,
  output logic       PCEn,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic [2:0] ALUSel,
  output logic       illegal,
  output logic [3:0] state
);

  localparam logic [3:0] FETCH     = 4'd0;
  localparam logic [3:0] DECODE    = 4'd1;
  localparam logic [3:0] MEM_ADDR  = 4'd2;
  localparam logic [3:0] MEM_READ  = 4'd3;
  localparam logic [3:0] MEM_WB    = 4'd4;
  localparam logic [3:0] MEM_WRITE = 4'd5;
  localparam logic [3:0] R_EXEC    = 4'd6;
  localparam logic [3:0] R_WB      = 4'd7;
  localparam logic [3:0] I_EXEC    = 4'd8;
  localparam logic [3:0] I_WB      = 4'd9;
  localparam logic [3:0] BRANCH    = 4'd10;
  localparam logic [3:0] JUMP      = 4'd11;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_J    = 6'h02;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  logic [3:0] cur, nxt;
  logic [2:0] r_sel;
  logic       r_ok;

  assign state = cur;

  always_comb begin
    r_sel = ALU_ADD;
    r_ok  = 1'b1;
    case (func)
      6'h20:   r_sel = ALU_ADD;
      6'h22:   r_sel = ALU_SUB;
      6'h24:   r_sel = ALU_AND;
      6'h25:   r_sel = ALU_OR;
      6'h2A:   r_sel = ALU_SLT;
      default: r_ok  = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cur <= FETCH;
    else      cur <= nxt;
  end

  always_comb begin
    nxt = FETCH;
    case (cur)
      FETCH: nxt = DECODE;
      DECODE: begin
        case (opcode)
          OP_R:         nxt = R_EXEC;
          OP_LW, OP_SW: nxt = MEM_ADDR;
          OP_ADDI:      nxt = I_EXEC;
          OP_BEQ:       nxt = BRANCH;
          OP_J:         nxt = JUMP;
          default:      nxt = FETCH;
        endcase
      end
      MEM_ADDR: nxt = (opcode == OP_SW) ? MEM_WRITE : MEM_READ;
      MEM_READ: nxt = MEM_WB;
      R_EXEC:   nxt = r_ok ? R_WB : FETCH;
      I_EXEC:   nxt = I_WB;
      default:  nxt = FETCH;
    endcase
  end

  // While reset is held every output sits at its default, so FETCH's enables
  // cannot leak out before the first real edge.
  always_comb begin
    PCEn     = 1'b0;
    IorD     = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    MemtoReg = 1'b0;
    IRWrite  = 1'b0;
    RegWrite = 1'b0;
    RegDst   = 1'b0;
    ALUSrcA  = 1'b0;
    ALUSrcB  = 2'b00;
    PCSource = 2'b00;
    ALUSel   = ALU_ADD;
    illegal  = 1'b0;
    if (rst) begin
      case (cur)
        FETCH: begin
          MemRead = 1'b1;
          IRWrite = 1'b1;
          ALUSrcB = 2'b01;
          PCEn    = 1'b1;
        end
        DECODE: begin
          ALUSrcB = 2'b10;
          illegal = !(opcode == OP_R  || opcode == OP_LW   || opcode == OP_SW ||
                      opcode == OP_ADDI || opcode == OP_BEQ || opcode == OP_J);
        end
        R_EXEC: begin
          ALUSrcA = 1'b1;
          ALUSel  = r_ok ? r_sel : ALU_ADD;
          illegal = !r_ok;
        end
        R_WB: begin
          ALUSrcA  = 1'b1;
          ALUSel   = r_sel;
          RegWrite = 1'b1;
          RegDst   = 1'b1;
        end
        I_EXEC, MEM_ADDR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
        end
        I_WB: begin
          ALUSrcA  = 1'b1;
          ALUSrcB  = 2'b10;
          RegWrite = 1'b1;
        end
        MEM_READ: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
          IorD    = 1'b1;
          MemRead = 1'b1;
        end
        MEM_WB: begin
          ALUSrcA  = 1'b1;
          ALUSrcB  = 2'b10;
          IorD     = 1'b1;
          MemRead  = 1'b1;
          MemtoReg = 1'b1;
          RegWrite = 1'b1;
        end
        MEM_WRITE: begin
          ALUSrcA  = 1'b1;
          ALUSrcB  = 2'b10;
          IorD     = 1'b1;
          MemWrite = 1'b1;
        end
        BRANCH: begin
          ALUSrcA  = 1'b1;
          ALUSel   = ALU_SUB;
          PCSource = 2'b01;
          PCEn     = zero;
        end
        JUMP: begin
          PCSource = 2'b10;
          PCEn     = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
